adder_arbiter: RTL and testbench



---
 rtl/adder_arbiter.sv | 107 ++++++++++
 tb/tb_adder_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - four requesters time-share one 64-bit adder under round-robin arbitration
module adder_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W:0]        res_sum,
  output logic [1:0]        res_id,
  output logic              busy,
  output logic [15:0]       ops_done
);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t       state, state_next;
  logic [1:0]   ptr;
  logic [1:0]   grant_id;
  logic [1:0]   idx;
  logic         grant_any;
  logic [W-1:0] a_q, b_q;
  logic [W-1:0] a_sel, b_sel;
  logic [1:0]   id_q;
  logic [W:0]   sum;

  // Scan from the far end back to ptr so the last hit is the first in round-robin order.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = ptr;
    idx       = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
  end

  assign a_sel = req_a[grant_id*W +: W];
  assign b_sel = req_b[grant_id*W +: W];
  assign sum   = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && grant_any) begin
      req_ready = NREQ'(1) << grant_id;
    end
  end

  assign busy = !rst && (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = CALC;
      CALC:    state_next = HOLD;
      HOLD:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_id    <= '0;
      ops_done  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (grant_any) begin
            a_q  <= a_sel;
            b_q  <= b_sel;
            id_q <= grant_id;
          end
        end
        CALC: begin
          res_sum   <= sum;
          res_id    <= id_q;
          res_valid <= 1'b1;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            ptr       <= res_id + 2'd1;
            ops_done  <= ops_done + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed bench for adder_arbiter with a per-cycle reference model
module tb_adder_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [255:0] req_a, req_b;
  logic [3:0]   req_ready;
  logic         res_valid;
  logic         res_ready;
  logic [64:0]  res_sum;
  logic [1:0]   res_id;
  logic         busy;
  logic [15:0]  ops_done;

  adder_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_id(res_id), .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [64:0] sum; } result_t;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;
  bit hold_valid = 0;
  int grant_log[$];
  result_t res_log[$];

  // Reference model: one operation in flight, result shows one cycle after accept.
  bit          m_busy, m_have;
  int          m_ptr, m_id, m_ops;
  logic [64:0] m_sum;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_valid(input int p, input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_have = 0; m_ptr = 0; m_ops = 0; m_id = 0; m_sum = '0;
    end else if (!m_busy) begin
      int g;
      g = first_valid(m_ptr, req_valid);
      if (g >= 0) begin
        m_busy = 1; m_have = 0; m_id = g;
        m_sum = {1'b0, req_a[g*64 +: 64]} + {1'b0, req_b[g*64 +: 64]};
      end
    end else if (!m_have) begin
      m_have = 1;
    end else if (res_ready) begin
      m_busy = 0; m_have = 0; m_ptr = (m_id + 1) % 4; m_ops = (m_ops + 1) % 65536;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      int g;
      logic [3:0] exp_ready;
      exp_ready = 4'b0;
      g = first_valid(m_ptr, req_valid);
      if (!rst && !m_busy && g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      check("busy", busy, !rst && m_busy);
      check("res_valid", res_valid, m_have);
      check("ops_done", ops_done, m_ops);
      if (m_have) begin
        check("res_sum", res_sum, m_sum);
        check("res_id", res_id, m_id);
      end
    end
  end

  // Handshake monitor; a granted requester drops its request just after the accept edge.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      logic [3:0] g;
      g = req_valid & req_ready;
      if (res_valid && res_ready) begin
        result_t r;
        r.id = res_id; r.sum = res_sum;
        res_log.push_back(r);
      end
      for (int i = 0; i < 4; i++) if (g[i]) grant_log.push_back(i);
      if (g != 4'b0) begin
        @(posedge clk);
        #1;
        if (!hold_valid) req_valid = req_valid & ~g;
      end
    end
  end

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b);
    req_a[i*64 +: 64] = a;
    req_b[i*64 +: 64] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_results(input int n);
    int start = res_log.size();
    int t = 0;
    while (res_log.size() < start + n && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("result_timeout", res_log.size() >= start + n, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1; req_valid = 4'b0;
    repeat (2) @(posedge clk);
    #2 rst = 0;
  endtask

  initial begin
    int n;
    rst = 1; req_valid = 4'hF; req_a = '0; req_b = '0; res_ready = 1;
    @(posedge clk);
    cmp_en = 1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 4'b0);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_ops_done", ops_done, 0);

    // Single request, latency and literal sum
    @(posedge clk); #2;
    rst = 0; req_valid = 4'b0;
    set_req(0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1);
    @(posedge clk); #1;
    check("single_busy", busy, 1);
    check("single_early_valid", res_valid, 0);
    check("single_grant", grant_log[grant_log.size()-1], 0);
    @(posedge clk); #1;
    check("single_latency_valid", res_valid, 1);
    wait_results(1);
    check("single_sum", res_log[res_log.size()-1].sum, 65'd18446744073709551615);
    check("single_id", res_log[res_log.size()-1].id, 0);

    // Carry-out
    @(posedge clk); #2;
    set_req(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_results(1);
    check("carry_sum", res_log[res_log.size()-1].sum, 65'd36893488147419103230);
    check("carry_bit", res_log[res_log.size()-1].sum[64], 1);
    check("carry_id", res_log[res_log.size()-1].id, 2);

    // Four simultaneous requests after reset
    do_reset();
    n = res_log.size();
    set_req(0, 64'd184, 64'd1256);
    set_req(1, 64'd14, 64'd7);
    set_req(2, 64'd156596564, 64'd125556);
    set_req(3, 64'd8446744073709551614, 64'd10000000000000000000);
    wait_results(4);
    for (int i = 0; i < 4; i++) check("simul_id", res_log[n+i].id, i);
    check("simul_sum0", res_log[n].sum, 65'd1440);
    check("simul_sum1", res_log[n+1].sum, 65'd21);
    check("simul_sum2", res_log[n+2].sum, 65'd156722120);
    check("simul_sum3", res_log[n+3].sum, 65'd18446744073709551614);
    @(negedge clk);
    check("simul_ops_done", ops_done, 4);

    // Backpressure in HOLD
    @(posedge clk); #2;
    res_ready = 0;
    set_req(1, 64'd5, 64'd7);
    for (int t = 0; t < 20 && !res_valid; t++) @(negedge clk);
    check("bp_reached_hold", res_valid, 1);
    @(posedge clk); #2;
    set_req(0, 64'd100, 64'd200);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("bp_valid", res_valid, 1);
      check("bp_sum", res_sum, 65'd12);
      check("bp_id", res_id, 1);
      check("bp_req_ready", req_ready, 4'b0);
      check("bp_ops_done", ops_done, 4);
    end
    n = res_log.size();
    @(posedge clk); #2;
    res_ready = 1;
    wait_results(2);
    check("bp_first_id", res_log[n].id, 1);
    check("bp_next_id", res_log[n+1].id, 0);
    check("bp_next_sum", res_log[n+1].sum, 65'd300);
    @(negedge clk);
    check("bp_ops_after", ops_done, 6);

    // Fairness with requesters 1 and 3 always valid
    do_reset();
    n = grant_log.size();
    hold_valid = 1;
    set_req(1, 64'd1, 64'd1);
    set_req(3, 64'd3, 64'd3);
    for (int t = 0; t < 100 && grant_log.size() < n + 4; t++) @(posedge clk);
    check("fair_timeout", grant_log.size() >= n + 4, 1);
    #2 req_valid = 4'b0;
    hold_valid = 0;
    check("fair_g0", grant_log[n], 1);
    check("fair_g1", grant_log[n+1], 3);
    check("fair_g2", grant_log[n+2], 1);
    check("fair_g3", grant_log[n+3], 3);
    repeat (8) @(posedge clk);

    // Reset during CALC, then arbitration restarts from ptr 0
    @(posedge clk); #2;
    set_req(1, 64'd10, 64'd20);
    wait_results(1);
    @(posedge clk); #2;
    set_req(0, 64'd3, 64'd4);
    @(posedge clk); #2;
    rst = 1;
    @(posedge clk); #1;
    check("abort_valid", res_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_ops", ops_done, 0);
    #1;
    rst = 0; req_valid = 4'b0;
    n = res_log.size();
    set_req(1, 64'd2, 64'd2);
    set_req(3, 64'd9, 64'd9);
    wait_results(2);
    check("abort_first_id", res_log[n].id, 1);
    check("abort_first_sum", res_log[n].sum, 65'd4);
    check("abort_second_id", res_log[n+1].id, 3);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
